// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D-cache line-port arbiter.
// No logic; enums and constants only.
// Not applicable.
package arb_types;

    localparam int unsigned LINE_W_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        ICACHE = 2'd1,
        DCACHE = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/cache_arbiter_priority.sv
// Combinational grant decision: D-side first unless I-side has been starved.
// Latency: combinational.
// No backpressure; the caller only acts on the grant while idle.
module arb_priority #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic       i_req_i,
    input  logic       d_req_i,
    input  logic [2:0] starve_cnt_i,
    output logic       grant_i_o,
    output logic       grant_d_o
);

    logic i_forced;

    // I wins outright once D has taken STARVE_LIMIT consecutive grants over it.
    always_comb begin
        i_forced  = i_req_i && (starve_cnt_i == 3'(STARVE_LIMIT));
        grant_d_o = d_req_i && !i_forced;
        grant_i_o = i_req_i && !grant_d_o;
    end

endmodule

// File: rtl/register.sv
// Generic loadable register with synchronous active-high clear.
// Latency: 1 cycle from load to output.
// No backpressure; load is sampled every cycle.
module register #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // Hold value until load, clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_o <= '0;
        end else if (load) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one memory line port between I-cache fills and D-cache fills/writebacks.
// Latency: request in IDLE -> mem request next cycle; mem_resp -> requester resp next cycle.
// Requests are held until resp; one transaction in flight, memory may stall BUSY indefinitely.
module cache_arbiter
    import arb_types::*;
#(
    parameter int unsigned LINE_W       = LINE_W_DEFAULT,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [2:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              is_write_q, is_write_d;
    logic              grant_i, grant_d;
    logic              line_load;
    logic [LINE_W-1:0] line_q;

    arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .i_req_i      (i_read),
        .d_req_i      (d_read | d_write),
        .starve_cnt_i (starve_q),
        .grant_i_o    (grant_i),
        .grant_d_o    (grant_d)
    );

    // Returned line is held here so both caches see stable data after the port moves on.
    register #(
        .WIDTH (LINE_W)
    ) u_line_buf (
        .clk   (clk),
        .reset (reset),
        .load  (line_load),
        .d_i   (mem_rdata),
        .q_o   (line_q)
    );

    // State, owner, starvation count and latched request; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= NONE;
            starve_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
        end
    end

    // Next-state, grant capture and port outputs.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        line_load  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    // A simultaneous read+write request is served as a writeback.
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    is_write_d = d_write;
                    owner_d    = DCACHE;
                    state_d    = BUSY;
                    if (i_read && (starve_q != 3'(STARVE_LIMIT))) begin
                        starve_d = starve_q + 3'd1;
                    end
                end else if (grant_i) begin
                    addr_d     = i_addr;
                    wdata_d    = '0;
                    is_write_d = 1'b0;
                    owner_d    = ICACHE;
                    state_d    = BUSY;
                    starve_d   = '0;
                end
            end
            BUSY: begin
                mem_read  = !is_write_q;
                mem_write = is_write_q;
                if (mem_resp) begin
                    line_load = !is_write_q;
                    state_d   = RESP;
                end
            end
            RESP: begin
                i_resp  = (owner_q == ICACHE);
                d_resp  = (owner_q == DCACHE);
                owner_d = NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = line_q;
    assign d_rdata   = line_q;

    // Catch requesters that raise fill and writeback together.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == IDLE)) begin
            assert (!(d_read && d_write))
                else $error("cache_arbiter: d_read and d_write asserted together");
        end
    end

endmodule
